// File: rtl/ppu_bg_pkg.sv
// Shared constants, pixel type and masking rule for the background pixel pipeline.
package ppu_bg_pkg;

  localparam int SHIFT_W     = 16;
  localparam int ATTR_W      = 8;
  localparam int LEFT_CLIP_W = 8;

  typedef struct packed {
    logic [1:0] attr;
    logic [1:0] pattern;
  } bg_pixel_t;

  // Transparent pixels drop their attribute so downstream priority logic sees a clean zero.
  function automatic bg_pixel_t bg_mask(input bg_pixel_t pixel,
                                        input logic [7:0] pixelX,
                                        input logic       showBackground,
                                        input logic       showLeftBackground);
    bg_pixel_t res;
    res = pixel;
    if (!showBackground) begin
      res = '0;
    end else if ((pixelX < 8'(LEFT_CLIP_W)) && !showLeftBackground) begin
      res = '0;
    end
    if (res.pattern == 2'b00) begin
      res = '0;
    end
    return res;
  endfunction

endpackage

// File: rtl/bg_shift_plane.sv
// One bit-plane of the background serialiser: pattern shifter, attribute shifter
// and attribute latch, with a fine-X tap on each shifter.
module bg_shift_plane
  import ppu_bg_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clock_en,
  input  logic       shift_en,
  input  logic       reload_en,
  input  logic [7:0] tile_byte,
  input  logic       attr_bit,
  input  logic [2:0] fine_x,
  output logic       pat_bit,
  output logic       att_bit
);

  localparam int PAT_IDX_W = $clog2(SHIFT_W);
  localparam int ATT_IDX_W = $clog2(ATTR_W);

  logic [SHIFT_W-1:0]   pat_q, pat_d;
  logic [ATTR_W-1:0]    att_q, att_d;
  logic                 lat_q, lat_d;
  logic [PAT_IDX_W-1:0] pat_idx;
  logic [ATT_IDX_W-1:0] att_idx;

  // Shift happens before reload so the attribute shifter takes the old latch value.
  always_comb begin
    pat_d = pat_q;
    att_d = att_q;
    lat_d = lat_q;
    if (clock_en) begin
      if (shift_en) begin
        pat_d = {pat_q[SHIFT_W-2:0], 1'b0};
        att_d = {att_q[ATTR_W-2:0], lat_q};
      end
      if (reload_en) begin
        pat_d[7:0] = tile_byte;
        lat_d      = attr_bit;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pat_q <= '0;
      att_q <= '0;
      lat_q <= 1'b0;
    end else begin
      pat_q <= pat_d;
      att_q <= att_d;
      lat_q <= lat_d;
    end
  end

  always_comb begin
    pat_idx = PAT_IDX_W'(SHIFT_W - 1) - PAT_IDX_W'(fine_x);
    att_idx = ATT_IDX_W'(ATTR_W - 1) - ATT_IDX_W'(fine_x);
    pat_bit = pat_q[pat_idx];
    att_bit = att_q[att_idx];
  end

endmodule

// File: rtl/bg_pixel_shifter.sv
// Background pixel shifter: two bit-planes, fine-X select, masking and a
// registered 4-bit palette index per dot.
module bg_pixel_shifter
  import ppu_bg_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clock_EN,
  input  logic       shift_EN,
  input  logic       reload_EN,
  input  logic [7:0] tileLowByte,
  input  logic [7:0] tileHighByte,
  input  logic [1:0] tileAttribute_REG,
  input  logic [2:0] fineX,
  input  logic [7:0] pixelX,
  input  logic       showBackground,
  input  logic       showLeftBackground,
  output logic [3:0] pixel_OUT,
  output logic       opaque_OUT
);

  logic      p0, p1, a0, a1;
  bg_pixel_t raw_pix;
  bg_pixel_t masked_pix;
  bg_pixel_t pix_q, pix_d;
  logic      opq_q, opq_d;

  bg_shift_plane u_plane0 (
    .clock     (clock),
    .reset     (reset),
    .clock_en  (clock_EN),
    .shift_en  (shift_EN),
    .reload_en (reload_EN),
    .tile_byte (tileLowByte),
    .attr_bit  (tileAttribute_REG[0]),
    .fine_x    (fineX),
    .pat_bit   (p0),
    .att_bit   (a0)
  );

  bg_shift_plane u_plane1 (
    .clock     (clock),
    .reset     (reset),
    .clock_en  (clock_EN),
    .shift_en  (shift_EN),
    .reload_en (reload_EN),
    .tile_byte (tileHighByte),
    .attr_bit  (tileAttribute_REG[1]),
    .fine_x    (fineX),
    .pat_bit   (p1),
    .att_bit   (a1)
  );

  // Output samples the pre-shift taps, so it updates on hold dots too.
  always_comb begin
    raw_pix.attr    = {a1, a0};
    raw_pix.pattern = {p1, p0};
    masked_pix      = bg_mask(raw_pix, pixelX, showBackground, showLeftBackground);
    pix_d           = pix_q;
    opq_d           = opq_q;
    if (clock_EN) begin
      pix_d = masked_pix;
      opq_d = (masked_pix.pattern != 2'b00);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pix_q <= '0;
      opq_q <= 1'b0;
    end else begin
      pix_q <= pix_d;
      opq_q <= opq_d;
    end
  end

  assign pixel_OUT  = pix_q;
  assign opaque_OUT = opq_q;

endmodule

// File: tb/tb_bg_pixel_shifter.sv
// Randomised and directed bench for bg_pixel_shifter with an in-bench behavioural model.
module tb_bg_pixel_shifter;

  logic       clock = 1'b0;
  logic       reset;
  logic       clock_EN;
  logic       shift_EN;
  logic       reload_EN;
  logic [7:0] tileLowByte;
  logic [7:0] tileHighByte;
  logic [1:0] tileAttribute_REG;
  logic [2:0] fineX;
  logic [7:0] pixelX;
  logic       showBackground;
  logic       showLeftBackground;
  logic [3:0] pixel_OUT;
  logic       opaque_OUT;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  bg_pixel_shifter dut (
    .clock              (clock),
    .reset              (reset),
    .clock_EN           (clock_EN),
    .shift_EN           (shift_EN),
    .reload_EN          (reload_EN),
    .tileLowByte        (tileLowByte),
    .tileHighByte       (tileHighByte),
    .tileAttribute_REG  (tileAttribute_REG),
    .fineX              (fineX),
    .pixelX             (pixelX),
    .showBackground     (showBackground),
    .showLeftBackground (showLeftBackground),
    .pixel_OUT          (pixel_OUT),
    .opaque_OUT         (opaque_OUT)
  );

  always #5 clock = ~clock;

  // Behavioural model: plain integer registers updated by the stated shift/reload rules.
  int   m_plo, m_phi, m_alo, m_ahi;
  int   m_llo, m_lhi;
  int   m_pix;
  int   m_opq;
  int   mp0, mp1, ma0, ma1, mpat;

  always @(posedge clock) begin
    if (reset) begin
      m_plo = 0; m_phi = 0; m_alo = 0; m_ahi = 0;
      m_llo = 0; m_lhi = 0; m_pix = 0; m_opq = 0;
    end else if (clock_EN) begin
      mp0  = (m_plo >> (15 - int'(fineX))) & 1;
      mp1  = (m_phi >> (15 - int'(fineX))) & 1;
      ma0  = (m_alo >> (7 - int'(fineX))) & 1;
      ma1  = (m_ahi >> (7 - int'(fineX))) & 1;
      mpat = mp1 * 2 + mp0;
      if (!showBackground || (int'(pixelX) < 8 && !showLeftBackground) || mpat == 0)
        m_pix = 0;
      else
        m_pix = ma1 * 8 + ma0 * 4 + mpat;
      m_opq = (m_pix != 0) ? 1 : 0;
      if (shift_EN) begin
        m_plo = (m_plo * 2) % 65536;
        m_phi = (m_phi * 2) % 65536;
        m_alo = (m_alo * 2 + m_llo) % 256;
        m_ahi = (m_ahi * 2 + m_lhi) % 256;
      end
      if (reload_EN) begin
        m_plo = (m_plo - (m_plo % 256)) + int'(tileLowByte);
        m_phi = (m_phi - (m_phi % 256)) + int'(tileHighByte);
        m_llo = int'(tileAttribute_REG[0]);
        m_lhi = int'(tileAttribute_REG[1]);
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      total++;
      if (int'(pixel_OUT) != m_pix || int'(opaque_OUT) != m_opq) begin
        bad++;
        $display("FAIL model_cmp t=%0t pixel=%h opaque=%b want pixel=%0h opaque=%0d",
                 $time, pixel_OUT, opaque_OUT, m_pix, m_opq);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic step(input logic sh, input logic rl, input logic [7:0] lo,
                      input logic [7:0] hi, input logic [1:0] at);
    shift_EN          = sh;
    reload_EN         = rl;
    tileLowByte       = lo;
    tileHighByte      = hi;
    tileAttribute_REG = at;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 1'b0, 8'h00, 8'h00, 2'b00);
    reset = 1'b0;
  endtask

  // Tile F0/0F attr 10: four dots of {10,01}=9 then four of {10,10}=A, starting
  // at step 9 for fineX=0 and three steps earlier for fineX=3.
  task automatic run_seq(input logic [2:0] fx);
    int start;
    logic [3:0] want;
    start = 9 - int'(fx);
    do_reset();
    fineX = fx;
    for (int s = 0; s < 25; s++) begin
      if (s == 0)      step(1'b0, 1'b1, 8'hF0, 8'h0F, 2'b10);
      else if (s == 9) step(1'b1, 1'b1, 8'h00, 8'h00, 2'b00);
      else             step(1'b1, 1'b0, 8'h00, 8'h00, 2'b00);
      if (s >= start && s < start + 4)          want = 4'h9;
      else if (s >= start + 4 && s < start + 8) want = 4'hA;
      else                                      want = 4'h0;
      chk($sformatf("seq_fx%0d_s%0d_pix", fx, s), 32'(pixel_OUT), 32'(want));
      chk($sformatf("seq_fx%0d_s%0d_opq", fx, s), 32'(opaque_OUT), 32'(want != 4'h0));
    end
  endtask

  logic [15:0] sv_plo, sv_phi;
  logic [7:0]  sv_alo, sv_ahi;

  initial begin
    reset = 1'b1; clock_EN = 1'b1; shift_EN = 1'b0; reload_EN = 1'b0;
    tileLowByte = 8'h00; tileHighByte = 8'h00; tileAttribute_REG = 2'b00;
    fineX = 3'd0; pixelX = 8'd100; showBackground = 1'b1; showLeftBackground = 1'b1;
    @(posedge clock); @(posedge clock); @(negedge clock);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("reset_pix", 32'(pixel_OUT), 32'h0);
    chk("reset_opq", 32'(opaque_OUT), 32'h0);

    run_seq(3'd0);
    run_seq(3'd3);

    // Coincident shift+reload: 8001 -> 00AA, attribute shifter takes old latch.
    do_reset();
    fineX = 3'd0;
    step(1'b0, 1'b1, 8'h80, 8'h80, 2'b01);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h00, 8'h00, 2'b00);
    step(1'b0, 1'b1, 8'h01, 8'h01, 2'b00);
    chk("pre_sim_patlo", 32'(dut.u_plane0.pat_q), 32'h8001);
    step(1'b1, 1'b1, 8'hAA, 8'h55, 2'b11);
    chk("sim_patlo", 32'(dut.u_plane0.pat_q), 32'h00AA);
    chk("sim_pathi", 32'(dut.u_plane1.pat_q), 32'h0055);
    chk("sim_attlo", 32'(dut.u_plane0.att_q), 32'hFE);
    chk("sim_atthi", 32'(dut.u_plane1.att_q), 32'h00);
    chk("sim_latlo", 32'(dut.u_plane0.lat_q), 32'h1);

    // Left-column and background-enable masking on fully opaque data.
    do_reset();
    step(1'b0, 1'b1, 8'hFF, 8'hFF, 2'b11);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h00, 8'h00, 2'b00);
    showLeftBackground = 1'b0;
    for (int x = 0; x <= 8; x++) begin
      pixelX = 8'(x);
      step(1'b0, 1'b0, 8'h00, 8'h00, 2'b00);
      chk($sformatf("left_clip_x%0d_pix", x), 32'(pixel_OUT), (x < 8) ? 32'h0 : 32'hF);
      chk($sformatf("left_clip_x%0d_opq", x), 32'(opaque_OUT), (x < 8) ? 32'h0 : 32'h1);
    end
    showLeftBackground = 1'b1;
    showBackground = 1'b0;
    for (int k = 0; k < 4; k++) begin
      pixelX = (k == 0) ? 8'd0 : (k == 1) ? 8'd8 : (k == 2) ? 8'd128 : 8'd255;
      step(1'b0, 1'b0, 8'h00, 8'h00, 2'b00);
      chk($sformatf("bg_off_%0d_pix", k), 32'(pixel_OUT), 32'h0);
    end
    showBackground = 1'b1;
    pixelX = 8'd255;
    step(1'b0, 1'b0, 8'h00, 8'h00, 2'b00);
    chk("col255_pix", 32'(pixel_OUT), 32'hF);

    // Dot enable low: everything holds despite shift/reload requests.
    sv_plo = dut.u_plane0.pat_q; sv_phi = dut.u_plane1.pat_q;
    sv_alo = dut.u_plane0.att_q; sv_ahi = dut.u_plane1.att_q;
    clock_EN = 1'b0;
    showBackground = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'($urandom), 8'($urandom), 2'($urandom));
    chk("hold_patlo", 32'(dut.u_plane0.pat_q), 32'(sv_plo));
    chk("hold_pathi", 32'(dut.u_plane1.pat_q), 32'(sv_phi));
    chk("hold_attlo", 32'(dut.u_plane0.att_q), 32'(sv_alo));
    chk("hold_atthi", 32'(dut.u_plane1.att_q), 32'(sv_ahi));
    chk("hold_pix", 32'(pixel_OUT), 32'hF);
    clock_EN = 1'b1;
    showBackground = 1'b1;

    // Reset mid-line while the output is opaque.
    reset = 1'b1;
    step(1'b1, 1'b1, 8'hFF, 8'hFF, 2'b11);
    reset = 1'b0;
    chk("midreset_pix", 32'(pixel_OUT), 32'h0);
    chk("midreset_opq", 32'(opaque_OUT), 32'h0);
    chk("midreset_patlo", 32'(dut.u_plane0.pat_q), 32'h0);
    chk("midreset_pathi", 32'(dut.u_plane1.pat_q), 32'h0);
    chk("midreset_attlo", 32'(dut.u_plane0.att_q), 32'h0);
    chk("midreset_atthi", 32'(dut.u_plane1.att_q), 32'h0);

    // Random traffic, compared against the model every cycle.
    for (int c = 0; c < 4000; c++) begin
      reset              = ($urandom_range(0, 96) == 0);
      clock_EN           = ($urandom_range(0, 4) != 0);
      fineX              = 3'($urandom);
      pixelX             = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      showBackground     = ($urandom_range(0, 7) != 0);
      showLeftBackground = ($urandom_range(0, 1) != 0);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
           8'($urandom), 8'($urandom), 2'($urandom));
    end
    reset = 1'b0;
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
